// File: rtl/firing_control.sv
// Trigger conditioning and firing sequencer: synchronizes and debounces the fire button,
// then issues HOLD / SHOT / COOLDOWN / RELOAD commands to the firing datapath.
module firing_control #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int COOLDOWN_CYCLES = 8,
    parameter int RELOAD_CYCLES   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       trigger,
    input  logic       reload_req,
    input  logic       round_active,
    input  logic [1:0] remaining_shots,
    output logic [2:0] control,
    output logic       shot_fired,
    output logic       dry_fire,
    output logic       busy
);

    typedef enum logic [1:0] {
        HOLD,
        SHOT,
        COOLDOWN,
        RELOAD
    } state_t;

    localparam logic [2:0]  CTRL_RELOAD = 3'b000;
    localparam logic [2:0]  CTRL_HOLD   = 3'b001;
    localparam logic [2:0]  CTRL_SHOT   = 3'b011;
    localparam logic [15:0] DEB_LAST    = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] COOL_LAST   = 16'(COOLDOWN_CYCLES - 1);
    localparam logic [15:0] RELOAD_LAST = 16'(RELOAD_CYCLES - 1);

    logic [1:0]  sync_q;
    logic        deb_level;
    logic        deb_prev;
    logic [15:0] deb_count;
    logic        press;

    state_t      state;
    state_t      next_state;
    logic [15:0] count;
    logic [15:0] next_count;
    logic        next_dry;
    logic [2:0]  next_control;

    // Debounced level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q    <= 2'b00;
            deb_level <= 1'b0;
            deb_prev  <= 1'b0;
            deb_count <= 16'd0;
        end else begin
            sync_q   <= {sync_q[0], trigger};
            deb_prev <= deb_level;
            if (sync_q[1] != deb_level) begin
                if (deb_count == DEB_LAST) begin
                    deb_level <= sync_q[1];
                    deb_count <= 16'd0;
                end else begin
                    deb_count <= deb_count + 16'd1;
                end
            end else begin
                deb_count <= 16'd0;
            end
        end
    end

    assign press = deb_level & ~deb_prev;

    always_comb begin
        next_state   = state;
        next_count   = count;
        next_dry     = 1'b0;
        next_control = CTRL_HOLD;
        unique case (state)
            HOLD: begin
                if (press && round_active && remaining_shots != 2'd0) begin
                    next_state = SHOT;
                end else if (reload_req && round_active) begin
                    next_state = RELOAD;
                    next_count = RELOAD_LAST;
                end else if (press && round_active) begin
                    next_dry = 1'b1;
                end
            end
            SHOT: begin
                next_state = COOLDOWN;
                next_count = COOL_LAST;
            end
            COOLDOWN, RELOAD: begin
                if (!round_active) begin
                    next_state = HOLD;
                    next_count = 16'd0;
                end else if (count == 16'd0) begin
                    next_state = HOLD;
                end else begin
                    next_count = count - 16'd1;
                end
            end
            default: begin
                next_state = HOLD;
                next_count = 16'd0;
            end
        endcase
        // Outputs are registered, so they are derived from the state being entered.
        if (next_state == SHOT) begin
            next_control = CTRL_SHOT;
        end else if (next_state == RELOAD) begin
            next_control = CTRL_RELOAD;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= HOLD;
            count      <= 16'd0;
            control    <= CTRL_HOLD;
            shot_fired <= 1'b0;
            dry_fire   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= next_state;
            count      <= next_count;
            control    <= next_control;
            shot_fired <= (next_state == SHOT);
            dry_fire   <= next_dry;
            busy       <= (next_state != HOLD);
        end
    end

endmodule

// File: tb/tb_firing_control.sv
// Self-checking bench for firing_control: scenario table, hand-written corner sequences
// and a randomized run compared every cycle against a behavioural model.
module tb_firing_control;

    localparam int DEB  = 4;
    localparam int COOL = 8;
    localparam int REL  = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       trigger;
    logic       reload_req;
    logic       round_active;
    logic [1:0] remaining_shots;
    logic [2:0] control;
    logic       shot_fired;
    logic       dry_fire;
    logic       busy;

    int errors = 0;
    int checks = 0;

    firing_control #(
        .DEBOUNCE_CYCLES(DEB),
        .COOLDOWN_CYCLES(COOL),
        .RELOAD_CYCLES  (REL)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .trigger        (trigger),
        .reload_req     (reload_req),
        .round_active   (round_active),
        .remaining_shots(remaining_shots),
        .control        (control),
        .shot_fired     (shot_fired),
        .dry_fire       (dry_fire),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Behavioural model: trigger sample history, mismatch run length, and a mode with cycles left.
    localparam int M_HOLD = 0, M_SHOT = 1, M_COOL = 2, M_RELOAD = 3;
    int m_s1, m_s2, m_deb, m_debp, m_run, m_mode, m_left;
    bit m_dry;

    function automatic void model_reset();
        m_s1 = 0; m_s2 = 0; m_deb = 0; m_debp = 0; m_run = 0;
        m_mode = M_HOLD; m_left = 0; m_dry = 0;
    endfunction

    function automatic void model_step();
        bit press;
        int old_deb;
        if (reset) begin
            model_reset();
            return;
        end
        press = (m_deb == 1) && (m_debp == 0);
        m_dry = 0;
        case (m_mode)
            M_HOLD: begin
                if (press && round_active && remaining_shots != 0) m_mode = M_SHOT;
                else if (reload_req && round_active) begin
                    m_mode = M_RELOAD;
                    m_left = REL;
                end else if (press && round_active) m_dry = 1;
            end
            M_SHOT: begin
                m_mode = M_COOL;
                m_left = COOL;
            end
            default: begin
                if (!round_active) m_mode = M_HOLD;
                else begin
                    m_left = m_left - 1;
                    if (m_left == 0) m_mode = M_HOLD;
                end
            end
        endcase
        old_deb = m_deb;
        if (m_s2 != m_deb) begin
            m_run = m_run + 1;
            if (m_run == DEB) begin
                m_deb = m_s2;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        m_debp = old_deb;
        m_s2 = m_s1;
        m_s1 = int'(trigger);
    endfunction

    function automatic logic [5:0] model_outputs();
        logic [2:0] c;
        c = (m_mode == M_SHOT) ? 3'b011 : (m_mode == M_RELOAD) ? 3'b000 : 3'b001;
        return {c, m_mode == M_SHOT, m_dry, m_mode != M_HOLD};
    endfunction

    task automatic checkVal(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input string name);
        logic [5:0] got;
        logic [5:0] exp;
        got = {control, shot_fired, dry_fire, busy};
        exp = model_outputs();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got {control,shot,dry,busy}=%b, expected %b at %0t",
                     name, got, exp, $time);
        end
    endtask

    int cnt_shot, cnt_dry, cnt_busy, cnt_cool, cnt_reload;

    task automatic clearCounts();
        cnt_shot = 0; cnt_dry = 0; cnt_busy = 0; cnt_cool = 0; cnt_reload = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        checkOutput("cycle");
        cnt_shot   += int'(shot_fired);
        cnt_dry    += int'(dry_fire);
        cnt_busy   += int'(busy);
        cnt_cool   += int'(busy && !shot_fired && control == 3'b001);
        cnt_reload += int'(control == 3'b000);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    typedef struct {
        int         len;
        bit         ra;
        logic [1:0] shots;
        int         exp_shots;
        int         exp_dry;
        int         exp_busy;
    } vec_t;

    vec_t vecs[6];

    task automatic applyStimulus(input vec_t v, input int idx);
        clearCounts();
        round_active    = v.ra;
        remaining_shots = v.shots;
        trigger         = 1'b1;
        ticks(v.len);
        trigger = 1'b0;
        ticks(50 - v.len);
        checkVal($sformatf("vec%0d_shots", idx), cnt_shot, v.exp_shots);
        checkVal($sformatf("vec%0d_dry", idx), cnt_dry, v.exp_dry);
        checkVal($sformatf("vec%0d_busy", idx), cnt_busy, v.exp_busy);
        round_active = 1'b1;
    endtask

    task automatic firstShotTick(input int limit, output int at);
        at = -1;
        for (int k = 1; k <= limit; k++) begin
            tick();
            if (shot_fired && at < 0) at = k;
        end
    endtask

    initial begin
        int at;
        int trig_left;
        int ra_off;

        vecs[0] = '{len: 3,  ra: 1'b1, shots: 2'd3, exp_shots: 0, exp_dry: 0, exp_busy: 0};
        vecs[1] = '{len: 4,  ra: 1'b1, shots: 2'd3, exp_shots: 1, exp_dry: 0, exp_busy: 1 + COOL};
        vecs[2] = '{len: 30, ra: 1'b1, shots: 2'd2, exp_shots: 1, exp_dry: 0, exp_busy: 1 + COOL};
        vecs[3] = '{len: 10, ra: 1'b1, shots: 2'd0, exp_shots: 0, exp_dry: 1, exp_busy: 0};
        vecs[4] = '{len: 10, ra: 1'b0, shots: 2'd3, exp_shots: 0, exp_dry: 0, exp_busy: 0};
        vecs[5] = '{len: 2,  ra: 1'b1, shots: 2'd1, exp_shots: 0, exp_dry: 0, exp_busy: 0};

        reset = 1'b1; trigger = 1'b0; reload_req = 1'b0; round_active = 1'b1;
        remaining_shots = 2'd3;
        model_reset();
        clearCounts();
        #2;
        checkVal("reset_control", int'(control), 1);
        checkVal("reset_flags", int'({shot_fired, dry_fire, busy}), 0);
        ticks(2);
        reset = 1'b0;
        ticks(3);

        // Held trigger: one shot, seven cycles after assertion.
        clearCounts();
        trigger = 1'b1;
        firstShotTick(30, at);
        checkVal("first_shot_latency", at, DEB + 3);
        checkVal("held_single_shot", cnt_shot, 1);
        trigger = 1'b0;
        ticks(20);

        for (int i = 0; i < 6; i++) applyStimulus(vecs[i], i);

        // Second press arriving during cooldown is dropped.
        clearCounts();
        trigger = 1'b1; ticks(5);
        trigger = 1'b0; ticks(4);
        trigger = 1'b1; ticks(12);
        trigger = 1'b0; ticks(30);
        checkVal("cooldown_press_dropped", cnt_shot, 1);
        checkVal("cooldown_busy_cycles", cnt_cool, COOL);

        // Empty magazine press coinciding with reload request: reload wins, no dry fire.
        clearCounts();
        remaining_shots = 2'd0;
        trigger = 1'b1; ticks(6);
        reload_req = 1'b1; tick();
        reload_req = 1'b0; ticks(30);
        trigger = 1'b0; ticks(15);
        checkVal("reload_cycles", cnt_reload, REL);
        checkVal("reload_no_dry", cnt_dry, 0);
        checkVal("reload_no_shot", cnt_shot, 0);
        remaining_shots = 2'd3;

        // Reload aborted by round_active dropping in its fifth cycle.
        reload_req = 1'b1; tick();
        reload_req = 1'b0; ticks(4);
        checkVal("reload_in_progress", int'(control), 0);
        round_active = 1'b0; tick();
        checkVal("reload_abort_control", int'(control), 1);
        checkVal("reload_abort_busy", int'(busy), 0);
        round_active = 1'b1; ticks(5);

        // Reset during cooldown with trigger held through release.
        clearCounts();
        trigger = 1'b1; ticks(10);
        checkVal("in_cooldown_busy", int'(busy), 1);
        #2 reset = 1'b1;
        #1 model_reset();
        checkVal("async_reset_control", int'(control), 1);
        checkVal("async_reset_flags", int'({shot_fired, dry_fire, busy}), 0);
        ticks(2);
        reset = 1'b0;
        firstShotTick(30, at);
        checkVal("post_reset_shot_latency", at, DEB + 3);
        trigger = 1'b0; ticks(20);

        // Randomized traffic checked every cycle against the model.
        trig_left = 1; ra_off = 0;
        for (int c = 0; c < 3000; c++) begin
            trig_left--;
            if (trig_left <= 0) begin
                trigger   = ~trigger;
                trig_left = $urandom_range(1, 14);
            end
            if (ra_off > 0) ra_off--;
            else if ($urandom_range(0, 40) == 0) ra_off = $urandom_range(1, 6);
            round_active = (ra_off == 0);
            reload_req   = ($urandom_range(0, 25) == 0);
            if ($urandom_range(0, 30) == 0) remaining_shots = 2'($urandom_range(0, 3));
            reset = (c == 1500 || c == 1501);
            tick();
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
